// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } recode_sel_e;

    // Two multiplier bits retire per step; the extra step covers the two extension bits.
    function automatic int unsigned booth_iters(input int unsigned width);
        return (width / 32'd2) + 32'd1;
    endfunction

endpackage

// File: rtl/booth_recode_w.sv
// Radix-4 Booth recoder: maps a multiplier triplet onto an addend and carry-in.
module booth_recode_w
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] m_ext,
    output logic [WIDTH+2:0] addend,
    output logic             carry_in
);

    recode_sel_e      sel;
    logic [WIDTH+2:0] m_w;
    logic [WIDTH+2:0] m2_w;

    assign m_w  = {m_ext[WIDTH+1], m_ext};
    assign m2_w = {m_ext, 1'b0};

    // Triplet decode into a select code.
    always_comb begin
        sel = ZERO;
        case (triplet)
            3'b001, 3'b010: sel = PM;
            3'b011:         sel = P2M;
            3'b100:         sel = N2M;
            3'b101, 3'b110: sel = NM;
            default:        sel = ZERO;
        endcase
    end

    // Negative terms are one's complement here; the adder supplies the +1.
    always_comb begin
        addend   = {(WIDTH+3){1'b0}};
        carry_in = 1'b0;
        case (sel)
            PM:  addend = m_w;
            P2M: addend = m2_w;
            NM: begin
                addend   = ~m_w;
                carry_in = 1'b1;
            end
            N2M: begin
                addend   = ~m2_w;
                carry_in = 1'b1;
            end
            default: begin
                addend   = {(WIDTH+3){1'b0}};
                carry_in = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with start/ready/done handshake and overflow flag.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int            N    = booth_iters(WIDTH);
    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e             state_q, state_d;
    logic [WIDTH+2:0]   a_q, a_d;
    logic [WIDTH+1:0]   m_q, m_d;
    logic [WIDTH+1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH+2:0]   addend_s;
    logic               cin_s;
    logic [WIDTH+2:0]   a_sum_s;
    logic [WIDTH+2:0]   a_shift_s;
    logic [WIDTH+1:0]   q_shift_s;
    logic [2*WIDTH-1:0] prod_fin_s;
    logic               ovf_fin_s;

    booth_recode_w #(.WIDTH(WIDTH)) u_recode (
        .triplet  ({q_q[1:0], qm1_q}),
        .m_ext    (m_q),
        .addend   (addend_s),
        .carry_in (cin_s)
    );

    assign a_sum_s    = a_q + addend_s + {{(WIDTH+2){1'b0}}, cin_s};
    assign a_shift_s  = {{2{a_sum_s[WIDTH+2]}}, a_sum_s[WIDTH+2:2]};
    assign q_shift_s  = {a_sum_s[1:0], q_q[WIDTH+1:2]};
    assign prod_fin_s = {a_shift_s[WIDTH-3:0], q_shift_s};

    // Signed results must sign-extend from bit WIDTH-1; unsigned ones need a zero upper half.
    always_comb begin
        if (mode_q) begin
            ovf_fin_s = !((&prod_fin_s[2*WIDTH-1:WIDTH-1]) || !(|prod_fin_s[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf_fin_s = |prod_fin_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        m_d        = m_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    ready_d = 1'b0;
                    a_d     = {(WIDTH+3){1'b0}};
                    m_d     = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
                    q_d     = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
                    qm1_d   = 1'b0;
                    mode_d  = signed_mode;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                a_d   = a_shift_s;
                q_d   = q_shift_s;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    ready_d    = 1'b1;
                    done_d     = 1'b1;
                    product_d  = prod_fin_s;
                    overflow_d = ovf_fin_s;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            a_q        <= {(WIDTH+3){1'b0}};
            m_q        <= {(WIDTH+2){1'b0}};
            q_q        <= {(WIDTH+2){1'b0}};
            qm1_q      <= 1'b0;
            mode_q     <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            product_q  <= {(2*WIDTH){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            m_q        <= m_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at WIDTH = 32.
module tb_booth_mult_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        ready;
    logic        done;
    logic [63:0] product;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product      (product),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic mode, input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        signed_mode  = mode;
        multiplicand = m;
        multiplier   = q;
    endtask

    // Counts edges from the accepting edge until done; pokes garbage and a stray start mid-run.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                start        = 1'b0;
                multiplicand = $urandom;
                multiplier   = $urandom;
                signed_mode  = ~signed_mode;
            end
            if (cyc == 3) begin
                start        = 1'b1;
                multiplicand = 32'h1234_5678;
                multiplier   = 32'h0BAD_F00D;
            end
            if (cyc == 5) start = 1'b0;
        end while (done !== 1'b1 && cyc < 60);
    endtask

    task automatic run_op(input string tag, input logic mode, input logic [31:0] m,
                          input logic [31:0] q, input logic [63:0] exp_p, input logic exp_ov);
        int cyc;
        start_op(mode, m, q);
        wait_done(cyc);
        check({tag, " latency"}, 64'(cyc), 64'd18);
        check({tag, " product"}, product, exp_p);
        check({tag, " overflow"}, {63'd0, overflow}, {63'd0, exp_ov});
        check({tag, " ready"}, {63'd0, ready}, 64'd1);
        @(negedge clock);
        check({tag, " done pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int          c;
        logic        hold_ok;
        logic        no_done;
        logic [63:0] e;
        logic        eov;
        logic        md;
        logic [31:0] rm, rq;

        reset        = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(negedge clock);
        check("reset ready", {63'd0, ready}, 64'd1);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset product", product, 64'd0);
        check("reset overflow", {63'd0, overflow}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        run_op("s 7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("u ffx ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op("s -1x-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
        run_op("s minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        run_op("s maxx2", 1'b1, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b1);
        run_op("u 2^16sq", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        run_op("u ffffsq", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0);
        run_op("s minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("s minx-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        run_op("s -1x5", 1'b1, 32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);

        // Back-to-back: second start presented in the done cycle.
        start_op(1'b0, 32'd5, 32'd6);
        wait_done(c);
        check("b2b first latency", 64'(c), 64'd18);
        check("b2b first product", product, 64'd30);
        start_op(1'b0, 32'd100, 32'd0);
        hold_ok = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (c == 1) start = 1'b0;
            if (c == 2) check("b2b ready in run", {63'd0, ready}, 64'd0);
            if (done !== 1'b1 && product !== 64'd30) hold_ok = 1'b0;
        end while (done !== 1'b1 && c < 60);
        check("b2b spacing", 64'(c), 64'd18);
        check("b2b hold", {63'd0, hold_ok}, 64'd1);
        check("b2b second product", product, 64'd0);
        check("b2b second overflow", {63'd0, overflow}, 64'd0);
        @(negedge clock);

        // Leave a nonzero product, then reset mid-run with start also high.
        run_op("s pre-reset", 1'b1, 32'd3, 32'd4, 64'd12, 1'b0);
        start_op(1'b1, 32'h0000_1234, 32'h0000_5678);
        no_done = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            if (i == 1) start = 1'b0;
            if (i == 4) begin
                start        = 1'b1;
                multiplicand = $urandom;
            end
            if (i == 6) start = 1'b0;
            if (done === 1'b1) no_done = 1'b0;
        end
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);
        check("rst ready", {63'd0, ready}, 64'd1);
        check("rst product", product, 64'd0);
        check("rst overflow", {63'd0, overflow}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (done === 1'b1) no_done = 1'b0;
        end
        check("rst no done", {63'd0, no_done}, 64'd1);
        check("rst idle ready", {63'd0, ready}, 64'd1);

        // Random operand pairs against a behavioural reference product.
        for (int i = 0; i < 60; i++) begin
            md = i[0];
            rm = $urandom;
            rq = $urandom;
            if (i % 6 == 2) rm = 32'h8000_0000;
            if (i % 6 == 3) rq = 32'hFFFF_FFFF;
            if (md) begin
                e   = 64'($signed(rm)) * 64'($signed(rq));
                eov = !((&e[63:31]) || !(|e[63:31]));
            end else begin
                e   = {32'd0, rm} * {32'd0, rq};
                eov = |e[63:32];
            end
            run_op("rand", md, rm, rq, e, eov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
